// File: rtl/riscv_definitions.sv
// Shared pipeline types for the RISC-V core: bus widths, funct3 encodings,
// memory-stage FSM states and the store byte-lane helper.
package riscv_definitions;

    typedef logic [31:0] dataBus_u;
    typedef logic [4:0]  regAddr_t;
    typedef logic [3:0]  byteEn_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3ITypeLOAD_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } funct3STypeSTORE_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } memState_e;

    // Byte lanes touched by an access of the given size (funct3[1:0]) at offset off.
    function automatic byteEn_t access_be(input logic [1:0] size, input logic [1:0] off);
        byteEn_t be;
        case (size)
            2'b00:   be = byteEn_t'(4'b0001 << off);
            2'b01:   be = byteEn_t'(4'b0011 << off);
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module mem_load_align
    import riscv_definitions::*;
(
    input  logic [31:0]      rdata,
    input  logic [1:0]       off,
    input  funct3ITypeLOAD_e funct3,
    output logic [31:0]      load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension according to the load type.
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            LB:      load_data = {{24{byte_s[7]}}, byte_s};
            LH:      load_data = {{16{half_s[15]}}, half_s};
            LBU:     load_data = {24'h000000, byte_s};
            LHU:     load_data = {16'h0000, half_s};
            LW:      load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory access stage: data-memory handshake, store lane steering, load
// extraction, pipeline stall and the MA->WB register.
module memory_access
    import riscv_definitions::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [31:0]      alu_ma,
    input  logic [31:0]      rs2_ma,
    input  logic             rd0_wr_en_ma,
    input  logic             data_rd_en_ma,
    input  logic             data_wr_en_ma,
    input  funct3ITypeLOAD_e funct3_ma,
    input  logic [4:0]       rd0_addr_ma,
    output logic             data_req,
    output logic             data_we,
    output logic [31:0]      data_addr,
    output logic [3:0]       data_be,
    output logic [31:0]      data_wdata,
    input  logic             data_ack,
    input  logic [31:0]      data_rdata,
    output logic             stall_ma,
    output logic             misalign_ma,
    output logic [31:0]      rd0_data_wb,
    output logic [4:0]       rd0_addr_wb,
    output logic             rd0_wr_en_wb
);

    memState_e   state_r;
    logic [31:0] buf_r;
    logic [2:0]  f3_s;
    logic [1:0]  off_s;
    logic        is_mem_s;
    logic        misalign_s;
    logic        pending_s;
    logic        is_load_s;
    logic [31:0] store_data_s;
    logic [31:0] load_word_s;
    logic [31:0] load_data_s;
    logic [31:0] wb_data_s;

    assign f3_s     = funct3_ma;
    assign off_s    = alu_ma[1:0];
    assign is_mem_s = data_rd_en_ma | data_wr_en_ma;
    assign is_load_s = data_rd_en_ma & ~data_wr_en_ma;

    // Alignment check on the access size carried in funct3[1:0].
    always_comb begin
        case (f3_s[1:0])
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = off_s[0];
            default: misalign_s = (off_s != 2'b00);
        endcase
    end

    // Store data is replicated across lanes; data_be selects which lanes land.
    always_comb begin
        case (f3_s[1:0])
            2'b00:   store_data_s = {4{rs2_ma[7:0]}};
            2'b01:   store_data_s = {2{rs2_ma[15:0]}};
            default: store_data_s = rs2_ma;
        endcase
    end

    // Reset gates the request so it drops at once, not at the next edge.
    assign pending_s   = rst_n & is_mem_s & ~misalign_s & (state_r != HOLD);
    assign misalign_ma = is_mem_s & misalign_s;
    assign stall_ma    = pending_s & ~data_ack;
    assign data_req    = pending_s;
    assign data_we     = pending_s & data_wr_en_ma;
    assign data_be     = pending_s ? access_be(f3_s[1:0], off_s) : 4'h0;
    assign data_addr   = {alu_ma[31:2], 2'b00};
    assign data_wdata  = store_data_s;

    // In HOLD the bus may already carry unrelated data, so use the captured word.
    assign load_word_s = (state_r == HOLD) ? buf_r : data_rdata;
    assign wb_data_s   = is_load_s ? load_data_s : alu_ma;

    mem_load_align u_load_align (
        .rdata     (load_word_s),
        .off       (off_s),
        .funct3    (funct3_ma),
        .load_data (load_data_s)
    );

    // Handshake FSM; a completed access with the pipeline frozen parks in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            buf_r   <= 32'h00000000;
        end else begin
            case (state_r)
                IDLE, WAIT: begin
                    if (pending_s && data_ack) begin
                        if (clk_en) begin
                            state_r <= IDLE;
                        end else begin
                            buf_r   <= data_rdata;
                            state_r <= HOLD;
                        end
                    end else if (pending_s) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HOLD: begin
                    if (clk_en) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // MA->WB register; stores and misaligned accesses never write a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_data_wb  <= 32'h00000000;
            rd0_addr_wb  <= 5'd0;
            rd0_wr_en_wb <= 1'b0;
        end else if (clk_en && !stall_ma) begin
            rd0_data_wb  <= wb_data_s;
            rd0_addr_wb  <= rd0_addr_ma;
            rd0_wr_en_wb <= rd0_wr_en_ma & ~data_wr_en_ma & ~misalign_ma;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: a behavioural memory answers requests
// after a chosen number of wait cycles; expected WB results are queued per op.
module tb_memory_access;
    import riscv_definitions::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clk_en;
    logic [31:0]      alu_ma, rs2_ma;
    logic             rd0_wr_en_ma, data_rd_en_ma, data_wr_en_ma;
    funct3ITypeLOAD_e funct3_ma;
    logic [4:0]       rd0_addr_ma;
    logic             data_req, data_we;
    logic [31:0]      data_addr;
    logic [3:0]       data_be;
    logic [31:0]      data_wdata;
    logic             data_ack;
    logic [31:0]      data_rdata;
    logic             stall_ma, misalign_ma;
    logic [31:0]      rd0_data_wb;
    logic [4:0]       rd0_addr_wb;
    logic             rd0_wr_en_wb;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wen;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    memory_access dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .alu_ma(alu_ma), .rs2_ma(rs2_ma),
        .rd0_wr_en_ma(rd0_wr_en_ma), .data_rd_en_ma(data_rd_en_ma), .data_wr_en_ma(data_wr_en_ma),
        .funct3_ma(funct3_ma), .rd0_addr_ma(rd0_addr_ma),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_be(data_be),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .stall_ma(stall_ma), .misalign_ma(misalign_ma),
        .rd0_data_wb(rd0_data_wb), .rd0_addr_wb(rd0_addr_wb), .rd0_wr_en_wb(rd0_wr_en_wb)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic exp_misalign(input logic [2:0] f3, input logic [1:0] off);
        if (f3[1:0] == 2'b00) return 1'b0;
        if (f3[1:0] == 2'b01) return off[0];
        return off != 2'b00;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
        if (f3[1:0] == 2'b00) return 4'b0001 << off;
        if (f3[1:0] == 2'b01) return 4'b0011 << off;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h000000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic pop_compare(input string tag);
        wb_exp_t e;
        check_val({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({tag, "_wb_data"}, rd0_data_wb, e.data);
            check_val({tag, "_wb_addr"}, 32'(rd0_addr_wb), 32'(e.addr));
            check_val({tag, "_wb_wen"}, 32'(rd0_wr_en_wb), 32'(e.wen));
        end
    endtask

    task automatic clear_inputs();
        data_rd_en_ma = 1'b0;
        data_wr_en_ma = 1'b0;
        rd0_wr_en_ma  = 1'b0;
        alu_ma        = 32'h00000000;
        rd0_addr_ma   = 5'd0;
        data_ack      = 1'b0;
    endtask

    // Called just after a posedge: presents one instruction in MA and follows it to WB.
    task automatic issue(input string tag, input logic rd, input logic wr, input logic wen,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input logic [4:0] rda, input int waits);
        logic    mem, mis, go;
        wb_exp_t e;
        int      stalls;
        mem = rd | wr;
        mis = mem & exp_misalign(f3, addr[1:0]);
        go  = mem & ~mis;
        alu_ma = addr; rs2_ma = rs2; funct3_ma = funct3ITypeLOAD_e'(f3);
        data_rd_en_ma = rd; data_wr_en_ma = wr; rd0_wr_en_ma = wen; rd0_addr_ma = rda;
        data_rdata = rdata;
        data_ack = (!go || waits == 0);
        e.data = (rd & ~wr) ? exp_load(rdata, addr[1:0], f3) : addr;
        e.addr = rda;
        e.wen  = wen & ~wr & ~mis;
        sb_q.push_back(e);
        @(negedge clk);
        check_val({tag, "_req"}, 32'(data_req), 32'(go));
        check_val({tag, "_misalign"}, 32'(misalign_ma), 32'(mis));
        check_val({tag, "_we"}, 32'(data_we), 32'(go & wr));
        check_val({tag, "_be"}, 32'(data_be), go ? 32'(exp_be(f3, addr[1:0])) : 32'd0);
        if (go) check_val({tag, "_addr"}, data_addr, {addr[31:2], 2'b00});
        if (go && wr) check_val({tag, "_wdata"}, data_wdata, exp_wdata(f3, rs2));
        stalls = 0;
        if (go) begin
            for (int i = 0; i < waits; i++) begin
                if (stall_ma) stalls++;
                check_val({tag, "_req_held"}, 32'(data_req), 32'd1);
                @(posedge clk); #1;
                if (i == waits - 1) data_ack = 1'b1;
                @(negedge clk);
            end
            check_val({tag, "_stall_cycles"}, 32'(stalls), 32'(waits));
        end
        check_val({tag, "_stall_at_ack"}, 32'(stall_ma), 32'd0);
        @(posedge clk); #1;
        pop_compare(tag);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; rs2_ma = 32'h0; funct3_ma = LW; data_rdata = 32'h0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_wb_data", rd0_data_wb, 32'h0);
        check_val("rst_wb_addr", 32'(rd0_addr_wb), 32'd0);
        check_val("rst_wb_wen", 32'(rd0_wr_en_wb), 32'd0);
        check_val("rst_req", 32'(data_req), 32'd0);
        check_val("rst_stall", 32'(stall_ma), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue("sw0",   1'b0, 1'b1, 1'b0, SW,  32'h00000100, 32'hDEADBEEF, 32'h0,        5'd1, 0);
        issue("lb_w2", 1'b1, 1'b0, 1'b1, LB,  32'h00000103, 32'h0,        32'h80FF0000, 5'd7, 2);
        issue("lhu",   1'b1, 1'b0, 1'b1, LHU, 32'h00000102, 32'h0,        32'h8001ABCD, 5'd8, 0);
        issue("sh_mis",1'b0, 1'b1, 1'b1, SH,  32'h00000101, 32'h00005555, 32'h0,        5'd2, 0);
        issue("sb_w1", 1'b0, 1'b1, 1'b0, SB,  32'h00000102, 32'h11223344, 32'h0,        5'd0, 1);
        issue("sh2",   1'b0, 1'b1, 1'b0, SH,  32'h00000102, 32'hCAFE1234, 32'h0,        5'd0, 0);
        issue("lh_neg",1'b1, 1'b0, 1'b1, LH,  32'h00000202, 32'h0,        32'h9ABC0000, 5'd9, 0);
        issue("lw_w3", 1'b1, 1'b0, 1'b1, LW,  32'h00000204, 32'h0,        32'h13579BDF, 5'd10, 3);
        issue("lw_mis",1'b1, 1'b0, 1'b1, LW,  32'h00000206, 32'h0,        32'h0BADF00D, 5'd11, 0);
        issue("alu",   1'b0, 1'b0, 1'b1, LB,  32'h00000055, 32'h0,        32'h0,        5'd3, 0);
        issue("both",  1'b1, 1'b1, 1'b1, SW,  32'h00000300, 32'hA5A5A5A5, 32'h0,        5'd4, 0);
        issue("lbu",   1'b1, 1'b0, 1'b1, LBU, 32'h00000101, 32'h0,        32'h0000F000, 5'd5, 0);

        for (int k = 0; k < 8; k++) begin
            logic [2:0]  f3;
            logic [1:0]  off;
            logic [31:0] a;
            logic        st;
            st = k[0];
            case ($urandom_range(0, 4))
                0: f3 = LB; 1: f3 = LH; 2: f3 = LW; 3: f3 = LBU; default: f3 = LHU;
            endcase
            if (f3[1:0] == 2'b00) off = 2'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b01) off = {1'($urandom_range(0, 1)), 1'b0};
            else off = 2'b00;
            if (st) f3 = {1'b0, f3[1:0]};
            a = {$urandom, 2'b00} | 32'(off);
            issue("rand", ~st, st, 1'b1, f3, a, $urandom, $urandom, 5'($urandom_range(1, 31)),
                  int'($urandom_range(0, 2)));
        end

        // Ack with the pipeline frozen: data must be buffered and no second request raised.
        clk_en = 1'b0;
        alu_ma = 32'h00000400; funct3_ma = LW; data_rd_en_ma = 1'b1; rd0_wr_en_ma = 1'b1;
        rd0_addr_ma = 5'd12; data_ack = 1'b1; data_rdata = 32'h12345678;
        sb_q.push_back('{data: 32'h12345678, addr: 5'd12, wen: 1'b1});
        @(negedge clk);
        check_val("hold_first_req", 32'(data_req), 32'd1);
        check_val("hold_first_stall", 32'(stall_ma), 32'd0);
        @(posedge clk); #1;
        data_ack = 1'b0; data_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check_val("hold_no_req", 32'(data_req), 32'd0);
        check_val("hold_no_stall", 32'(stall_ma), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("hold_no_req2", 32'(data_req), 32'd0);
        @(posedge clk); #1;
        clk_en = 1'b1;
        @(negedge clk);
        check_val("hold_release_req", 32'(data_req), 32'd0);
        @(posedge clk); #1;
        pop_compare("hold");
        clear_inputs();

        // Reset in the middle of a wait-stated load.
        alu_ma = 32'h00000500; funct3_ma = LW; data_rd_en_ma = 1'b1; rd0_wr_en_ma = 1'b1;
        rd0_addr_ma = 5'd13; data_ack = 1'b0;
        @(negedge clk);
        check_val("rstw_req", 32'(data_req), 32'd1);
        check_val("rstw_stall", 32'(stall_ma), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("rstw_req_drop", 32'(data_req), 32'd0);
        check_val("rstw_stall_drop", 32'(stall_ma), 32'd0);
        check_val("rstw_wb_data", rd0_data_wb, 32'h0);
        check_val("rstw_wb_addr", 32'(rd0_addr_wb), 32'd0);
        check_val("rstw_wb_wen", 32'(rd0_wr_en_wb), 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        data_ack = 1'b1;
        @(posedge clk); #1;
        check_val("late_ack_req", 32'(data_req), 32'd0);
        data_ack = 1'b0;

        issue("recover", 1'b1, 1'b0, 1'b1, LW, 32'h00000600, 32'h0, 32'h0F1E2D3C, 5'd14, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
